// File: rtl/ysyx_23060187_mem_arbiter.sv
// Round-robin arbiter that shares one single-port memory between the IFU and the LSU.
// One transaction in flight at a time, valid/ready request handshake, timeout guard.
module ysyx_23060187_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_resp_err,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_resp_err,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            lastGrant_q, lastGrant_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic              memWen_q, memWen_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic [7:0]        memWmask_q, memWmask_d;
    logic [DATA_W-1:0] ifuRdata_q, ifuRdata_d;
    logic [DATA_W-1:0] lsuRdata_q, lsuRdata_d;
    logic              ifuErr_q, ifuErr_d;
    logic              lsuErr_q, lsuErr_d;

    logic              grantIfu, grantLsu;
    logic              timeoutHit;
    logic [7:0]        cntInc;
    logic              setResp;
    logic [DATA_W-1:0] respData;
    logic              respErr;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grantIfu = 1'b0;
        grantLsu = 1'b0;
        if (state_q == IDLE) begin
            if (ifu_req_valid && lsu_req_valid) begin
                if (lastGrant_q == OWN_LSU) begin
                    grantIfu = 1'b1;
                end else begin
                    grantLsu = 1'b1;
                end
            end else if (ifu_req_valid) begin
                grantIfu = 1'b1;
            end else if (lsu_req_valid) begin
                grantLsu = 1'b1;
            end
        end
    end

    // Saturating count keeps a late acceptance at the limit from wrapping past the guard.
    assign cntInc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign timeoutHit = (cnt_q >= TIMEOUT_LAST);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        cnt_d       = cnt_q;
        memAddr_d   = memAddr_q;
        memWen_d    = memWen_q;
        memWdata_d  = memWdata_q;
        memWmask_d  = memWmask_q;
        ifuRdata_d  = ifuRdata_q;
        lsuRdata_d  = lsuRdata_q;
        ifuErr_d    = ifuErr_q;
        lsuErr_d    = lsuErr_q;
        setResp     = 1'b0;
        respData    = '0;
        respErr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (grantIfu || grantLsu) begin
                    owner_d     = grantLsu ? OWN_LSU : OWN_IFU;
                    lastGrant_d = grantLsu ? OWN_LSU : OWN_IFU;
                    cnt_d       = 8'd0;
                    state_d     = REQ;
                    if (grantLsu) begin
                        memAddr_d  = lsu_addr;
                        memWen_d   = lsu_wen;
                        memWdata_d = lsu_wdata;
                        memWmask_d = lsu_wmask;
                    end else begin
                        memAddr_d  = ifu_addr;
                        memWen_d   = 1'b0;
                        memWdata_d = '0;
                        memWmask_d = 8'h00;
                    end
                end
            end
            REQ: begin
                cnt_d = cntInc;
                if (mem_req_ready) begin
                    state_d = WAIT;
                end else if (timeoutHit) begin
                    state_d = RESP;
                    setResp = 1'b1;
                    respErr = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cntInc;
                if (mem_resp_valid) begin
                    state_d  = RESP;
                    setResp  = 1'b1;
                    respData = mem_rdata;
                end else if (timeoutHit) begin
                    state_d = RESP;
                    setResp = 1'b1;
                    respErr = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Only the owner's result registers change, so the other side keeps its last value.
        if (setResp) begin
            if (owner_q == OWN_LSU) begin
                lsuRdata_d = respData;
                lsuErr_d   = respErr;
            end else begin
                ifuRdata_d = respData;
                ifuErr_d   = respErr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IFU;
            lastGrant_q <= OWN_LSU;
            cnt_q       <= 8'd0;
            memAddr_q   <= '0;
            memWen_q    <= 1'b0;
            memWdata_q  <= '0;
            memWmask_q  <= 8'h00;
            ifuRdata_q  <= '0;
            lsuRdata_q  <= '0;
            ifuErr_q    <= 1'b0;
            lsuErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
            cnt_q       <= cnt_d;
            memAddr_q   <= memAddr_d;
            memWen_q    <= memWen_d;
            memWdata_q  <= memWdata_d;
            memWmask_q  <= memWmask_d;
            ifuRdata_q  <= ifuRdata_d;
            lsuRdata_q  <= lsuRdata_d;
            ifuErr_q    <= ifuErr_d;
            lsuErr_q    <= lsuErr_d;
        end
    end

    assign ifu_req_ready  = grantIfu;
    assign lsu_req_ready  = grantLsu;

    assign mem_req_valid  = (state_q == REQ);
    assign mem_addr       = memAddr_q;
    assign mem_wen        = memWen_q;
    assign mem_wdata      = memWdata_q;
    assign mem_wmask      = memWmask_q;

    assign ifu_resp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
    assign lsu_resp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
    assign ifu_rdata      = ifuRdata_q;
    assign lsu_rdata      = lsuRdata_q;
    assign ifu_resp_err   = ifuErr_q;
    assign lsu_resp_err   = lsuErr_q;

endmodule

// File: tb/tb_ysyx_23060187_mem_arbiter.sv
// Scoreboard bench for the IFU/LSU memory arbiter: stimulus pushes expected responses,
// a monitor pops and compares them whenever a response pulse appears.
module tb_ysyx_23060187_mem_arbiter;

    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic        isLsu;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    exp_t        sbQ[$];
    int          checkCount;
    int          passCount;
    int          holdCycles;
    bit          memSilent;
    logic [31:0] memData;
    int          strayCount;

    ysyx_23060187_mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata     (ifu_rdata),
        .ifu_resp_err  (ifu_resp_err),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid),
        .lsu_rdata     (lsu_rdata),
        .lsu_resp_err  (lsu_resp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata     (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: holds ready low for holdCycles cycles of each request, then answers
    // one cycle after acceptance unless silenced; strayCount bumps inject an unsolicited pulse.
    initial begin : memModel
        int reqCycles;
        int strayDone;
        bit fire;
        reqCycles      = 0;
        strayDone      = 0;
        fire           = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
        forever begin
            @(negedge clk);
            fire = mem_req_valid && mem_req_ready && !memSilent;
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            if (fire) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = memData;
            end else if (strayCount != strayDone) begin
                strayDone      = strayCount;
                mem_resp_valid = 1'b1;
                mem_rdata      = 32'hDEADBEEF;
            end
            if (mem_req_valid) begin
                mem_req_ready = (reqCycles >= holdCycles);
                reqCycles++;
            end else begin
                reqCycles     = 0;
                mem_req_ready = 1'b1;
            end
        end
    end

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    task automatic checkOutput();
        exp_t        e;
        logic [31:0] gotData;
        logic        gotErr;
        forever begin
            @(negedge clk);
            if (ifu_resp_valid || lsu_resp_valid) begin
                if (sbQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpectedResp: got ifu_resp_valid=%b lsu_resp_valid=%b, expected no pulse at %0t",
                             ifu_resp_valid, lsu_resp_valid, $time);
                end else begin
                    e       = sbQ.pop_front();
                    gotData = e.isLsu ? lsu_rdata : ifu_rdata;
                    gotErr  = e.isLsu ? lsu_resp_err : ifu_resp_err;
                    checkValue("respOwner", 32'({ifu_resp_valid, lsu_resp_valid}), e.isLsu ? 32'd1 : 32'd2);
                    checkValue("respRdata", gotData, e.rdata);
                    checkValue("respErr", 32'(gotErr), 32'(e.err));
                end
            end
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkValue({tag, ".mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        checkValue({tag, ".mem_addr"}, mem_addr, 32'd0);
        checkValue({tag, ".mem_wen"}, 32'(mem_wen), 32'd0);
        checkValue({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        checkValue({tag, ".mem_wmask"}, 32'(mem_wmask), 32'd0);
        checkValue({tag, ".ifu_rdata"}, ifu_rdata, 32'd0);
        checkValue({tag, ".lsu_rdata"}, lsu_rdata, 32'd0);
        checkValue({tag, ".ifu_resp_err"}, 32'(ifu_resp_err), 32'd0);
        checkValue({tag, ".lsu_resp_err"}, 32'(lsu_resp_err), 32'd0);
        checkValue({tag, ".resp_valid"}, 32'({ifu_resp_valid, lsu_resp_valid}), 32'd0);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 40 && sbQ.size() != 0; i++) begin
            @(posedge clk);
        end
        checkValue("drain", 32'(sbQ.size()), 32'd0);
    endtask

    // One transaction from a single requester, tracking the request phase and response latency.
    task automatic applyStimulus(input bit isLsu, input logic [31:0] addr, input bit wen,
                                 input logic [31:0] wdata, input logic [7:0] wmask,
                                 input int hold, input bit silent, input logic [31:0] memWord,
                                 input logic [31:0] expRdata, input bit expErr, input int expLatency);
        exp_t e;
        bit   granted;
        int   lat;
        int   reqLen;
        int   badFields;
        holdCycles = hold;
        memSilent  = silent;
        memData    = memWord;
        @(posedge clk);
        #1;
        if (isLsu) begin
            lsu_req_valid = 1'b1;
            lsu_addr      = addr;
            lsu_wen       = wen;
            lsu_wdata     = wdata;
            lsu_wmask     = wmask;
        end else begin
            ifu_req_valid = 1'b1;
            ifu_addr      = addr;
        end
        granted = 1'b0;
        for (int w = 0; w < 20 && !granted; w++) begin
            @(negedge clk);
            granted = isLsu ? lsu_req_ready : ifu_req_ready;
        end
        if (!granted) begin
            checkCount++;
            $display("[TB] FAIL grantTimeout: got no req_ready, expected a grant (isLsu=%0d)", isLsu);
            ifu_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
            return;
        end
        e.isLsu = isLsu;
        e.rdata = expRdata;
        e.err   = expErr;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        lat       = 0;
        reqLen    = 0;
        badFields = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (mem_req_valid) begin
                reqLen++;
                if (mem_addr !== addr || mem_wen !== (isLsu ? wen : 1'b0) ||
                    mem_wmask !== (isLsu ? wmask : 8'h00) || (isLsu && mem_wdata !== wdata)) begin
                    badFields++;
                end
            end
            if (isLsu ? lsu_resp_valid : ifu_resp_valid) begin
                lat = cyc;
                break;
            end
        end
        checkValue("reqLen", 32'(reqLen), 32'(hold + 1));
        checkValue("reqFields", 32'(badFields), 32'd0);
        checkValue("latency", 32'(lat), 32'(expLatency));
        @(posedge clk);
        checkValue("respConsumed", 32'(sbQ.size()), 32'd0);
    endtask

    // Both requesters held valid; grants must alternate starting with the IFU.
    task automatic runTies(input int n, input logic [31:0] memWord);
        exp_t e;
        bit   expectIfu;
        int   grants;
        memSilent  = 1'b0;
        holdCycles = 0;
        memData    = memWord;
        @(posedge clk);
        #1;
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0100;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_2000;
        lsu_wen       = 1'b0;
        lsu_wdata     = 32'h0;
        lsu_wmask     = 8'h00;
        expectIfu = 1'b1;
        grants    = 0;
        for (int cyc = 0; cyc < 80 && grants < n; cyc++) begin
            @(negedge clk);
            if (ifu_req_ready || lsu_req_ready) begin
                checkValue("tieGrant", 32'({ifu_req_ready, lsu_req_ready}), expectIfu ? 32'd2 : 32'd1);
                e.isLsu = !expectIfu;
                e.rdata = memWord;
                e.err   = 1'b0;
                sbQ.push_back(e);
                expectIfu = !expectIfu;
                grants++;
            end
        end
        checkValue("tieCount", 32'(grants), 32'(n));
        @(posedge clk);
        #1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        waitDrain();
    endtask

    initial begin : mainSeq
        bit granted;
        checkCount    = 0;
        passCount     = 0;
        holdCycles    = 0;
        memSilent     = 1'b0;
        memData       = 32'h0;
        strayCount    = 0;
        rst           = 1'b1;
        ifu_req_valid = 1'b0;
        ifu_addr      = 32'h0;
        lsu_req_valid = 1'b0;
        lsu_addr      = 32'h0;
        lsu_wen       = 1'b0;
        lsu_wdata     = 32'h0;
        lsu_wmask     = 8'h00;
        fork
            checkOutput();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("reset");
        checkValue("idleReady", 32'({ifu_req_ready, lsu_req_ready}), 32'd0);

        runTies(6, 32'h0000_1111);

        applyStimulus(1'b0, 32'h8000_0000, 1'b0, 32'h0, 8'h00, 0, 1'b0,
                      32'h0010_0073, 32'h0010_0073, 1'b0, 3);

        applyStimulus(1'b1, 32'h8000_1000, 1'b1, 32'h0000_00AB, 8'h01, 0, 1'b0,
                      32'h5555_5555, 32'h5555_5555, 1'b0, 3);

        applyStimulus(1'b1, 32'h8000_2004, 1'b0, 32'h0, 8'h00, 5, 1'b0,
                      32'h1234_5678, 32'h1234_5678, 1'b0, 8);

        applyStimulus(1'b1, 32'h8000_3000, 1'b0, 32'h0, 8'h00, 0, 1'b1,
                      32'h0BAD_0BAD, 32'h0, 1'b1, TIMEOUT + 1);

        #1;
        strayCount++;
        repeat (5) @(negedge clk);
        checkValue("errHeld", 32'(lsu_resp_err), 32'd1);
        checkValue("rdataHeld", lsu_rdata, 32'd0);

        applyStimulus(1'b0, 32'h8000_0010, 1'b0, 32'h0, 8'h00, 0, 1'b0,
                      32'h0000_0013, 32'h0000_0013, 1'b0, 3);
        checkValue("lsuErrHeldAfterIfu", 32'(lsu_resp_err), 32'd1);

        memSilent  = 1'b1;
        holdCycles = 0;
        @(posedge clk);
        #1;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_4000;
        lsu_wen       = 1'b0;
        granted       = 1'b0;
        for (int w = 0; w < 20 && !granted; w++) begin
            @(negedge clk);
            granted = lsu_req_ready;
        end
        checkValue("midResetGrant", 32'(granted), 32'd1);
        @(posedge clk);
        #1;
        lsu_req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("midReset");
        repeat (20) @(negedge clk);

        runTies(1, 32'h0000_2222);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ysyx_23060187_mem_arbiter.md
Name: ysyx_23060187_mem_arbiter

Overview:
- Shares one single-port memory interface between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Replaces the dual-read-port memory access used by the single-cycle core. It is the first step toward a multi-cycle core.
- Handles one outstanding transaction at a time.
- Uses round-robin grant, a valid/ready request handshake and a timeout guard.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before an error response is forced (range 2..255).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ifu_req_valid  in  1  IFU fetch request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_resp_valid  out  1  one-cycle fetch response pulse.
- ifu_rdata  out  DATA_W  fetched instruction.
- ifu_resp_err  out  1  fetch timed out.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  load/store address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  8  byte write mask.
- lsu_resp_valid  out  1  one-cycle LSU response pulse.
- lsu_rdata  out  DATA_W  load data.
- lsu_resp_err  out  1  LSU access timed out.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_W  memory address.
- mem_wen  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_wmask  out  8  memory byte mask.
- mem_resp_valid  in  1  memory response pulse.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Registers: owner (IFU/LSU), last_grant (IFU/LSU), 8-bit timeout counter, latched request fields, latched response data/err.
- Reset (synchronous) forces:
  - state IDLE, last_grant=LSU, counter 0;
  - all outputs 0, including mem_addr, mem_wdata, mem_wmask, rdata and err.
  - If reset is asserted mid-transaction, the transaction is abandoned: no response pulse, and mem_req_valid=0 from the next cycle.
- IDLE:
  - Grant rule: only one requester valid → that one. Both valid → the one not equal to last_grant.
  - xxx_req_ready=1 combinationally only for the granted requester, only in IDLE; 0 in all other states.
  - On handshake: latch addr/wen/wdata/wmask into the mem_* registers, set owner and last_grant, clear the counter, go to REQ.
  - An IFU grant forces mem_wen=0 and mem_wmask=0.
- REQ:
  - mem_req_valid=1; mem_* held stable.
  - mem_req_ready=1 → WAIT; mem_req_valid drops next cycle.
- WAIT:
  - mem_resp_valid=1 → latch mem_rdata, err=0, go to RESP.
  - mem_resp_valid is sampled only in WAIT. The memory responds no earlier than the cycle after acceptance.
- Timeout:
  - The counter increments every cycle in REQ or WAIT.
  - When counter==TIMEOUT-1 and no advancing event occurs that cycle, go to RESP with err=1 and rdata=0, and drop mem_req_valid.
  - A completion in the same cycle wins over the timeout.
- RESP:
  - The owner's resp_valid=1 for exactly one cycle with registered rdata/err; the other requester's resp_valid stays 0.
  - Next state is IDLE.
  - For stores, rdata = whatever mem_rdata carried; the LSU ignores it.
- Latency: accept at cycle T, zero-wait memory → mem_req_valid at T+1, memory response at T+2, resp_valid at T+3. Minimum 4 cycles between back-to-back accepts.
- Stray mem_resp_valid outside WAIT (including after a timeout) is ignored.
- rdata and err outputs hold their last value between pulses.

Test Plan:
- IFU only, ifu_addr=0x80000000, mem_req_ready=1, mem_resp_valid at T+2 with 0x00100073 → mem_req_valid at T+1 with mem_addr=0x80000000, mem_wen=0; ifu_resp_valid at T+3, ifu_rdata=0x00100073, err=0; lsu_resp_valid stays 0.
- Both valid after reset → IFU granted first, lsu_req_ready=0. LSU granted at the next IDLE. Both valid again → IFU. Grants alternate for 6 consecutive ties.
- LSU store: addr=0x80001000, wdata=0x000000AB, wmask=0x01, wen=1 → mem_wen=1, mem_wmask=0x01, mem_wdata=0xAB; lsu_resp_valid one pulse, err=0.
- mem_req_ready held low for 5 cycles → mem_req_valid stays 1 for 6 cycles with mem_addr/wdata/wmask unchanged; no response until after acceptance.
- TIMEOUT=16, memory never responds → lsu_resp_err=1 and lsu_rdata=0 pulse 16 cycles after entering REQ. A later stray mem_resp_valid produces no pulse; the next IFU request is served normally.
- rst asserted for 1 cycle while in WAIT → next cycle IDLE, mem_req_valid=0, no resp_valid pulse. The first tie after reset is granted to IFU.
